fma_issue_queue: RTL and testbench

- Sits directly upstream of the combinational FP32 fused multiply-add core `Top`, which computes D = A*B + C.
- Buffers operand triples (A, B, C) arriving on a valid/ready interface in a small FIFO and drives the head entry onto the core's A/B/C inputs.
- Registers the core's D result into an output stage with its own valid/ready handshake.
- Tags each result with NaN/Inf flags, so sequential stimulus or a host can stream operations through the combinational core at up to one per clock.

---
 rtl/fma_issue_queue_if.sv | 36 +++
 rtl/fma_issue_queue.sv | 117 +++++++++++
 tb/tb_fma_issue_queue.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/fma_issue_queue_if.sv
// Operand/result bundle between the FMA issue queue, its producer, the core and the consumer.
// slave: queue side; master: producer/consumer/core side.
interface fma_issue_queue_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_c;
    logic [WIDTH-1:0] fma_a;
    logic [WIDTH-1:0] fma_b;
    logic [WIDTH-1:0] fma_c;
    logic [WIDTH-1:0] fma_d;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_d;
    logic             out_nan;
    logic             out_inf;
    logic [CNT_W-1:0] count;

    modport slave (
        input  in_valid, in_a, in_b, in_c,
        input  fma_d, out_ready,
        output in_ready, fma_a, fma_b, fma_c,
        output out_valid, out_d, out_nan, out_inf, count
    );

    modport master (
        output in_valid, in_a, in_b, in_c,
        output fma_d, out_ready,
        input  in_ready, fma_a, fma_b, fma_c,
        input  out_valid, out_d, out_nan, out_inf, count
    );
endinterface

// File: rtl/fma_issue_queue.sv
// FIFO of operand triples feeding a combinational FP32 FMA core, with a registered result stage.
// Optional: define FMA_FLUSH_DENORM_EN to flush subnormal results to signed zero.
module fma_issue_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic clk,
    input  logic rst,
    fma_issue_queue_if.slave io
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] memA [DEPTH];
    logic [WIDTH-1:0] memB [DEPTH];
    logic [WIDTH-1:0] memC [DEPTH];

    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] cnt;

    logic             outValid;
    logic [WIDTH-1:0] outD;
    logic             outNan;
    logic             outInf;

    logic             empty;
    logic             inReady;
    logic             push;
    logic             pop;

    logic [7:0]       dExp;
    logic [22:0]      dMan;
    logic             dNan;
    logic             dInf;
    logic [WIDTH-1:0] capD;

    assign empty   = (cnt == '0);
    assign inReady = (cnt != FULL);
    assign push    = io.in_valid && inReady;
    assign pop     = !empty && (!outValid || io.out_ready);

    // Storage needs no reset; entries are only read once counted.
    always_ff @(posedge clk) begin
        if (push) begin
            memA[wrPtr] <= io.in_a;
            memB[wrPtr] <= io.in_b;
            memC[wrPtr] <= io.in_c;
        end
    end

    always_comb begin
        io.fma_a = '0;
        io.fma_b = '0;
        io.fma_c = '0;
        if (!empty) begin
            io.fma_a = memA[rdPtr];
            io.fma_b = memB[rdPtr];
            io.fma_c = memC[rdPtr];
        end
    end

    assign dExp = io.fma_d[30:23];
    assign dMan = io.fma_d[22:0];
    assign dNan = (dExp == 8'hFF) && (dMan != '0);
    assign dInf = (dExp == 8'hFF) && (dMan == '0);

`ifdef FMA_FLUSH_DENORM_EN
    always_comb begin
        capD = io.fma_d;
        if (dExp == 8'h00 && dMan != '0)
            capD = {io.fma_d[WIDTH-1], {(WIDTH-1){1'b0}}};
    end
`else
    assign capD = io.fma_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            cnt      <= '0;
            outValid <= 1'b0;
            outD     <= '0;
            outNan   <= 1'b0;
            outInf   <= 1'b0;
        end else begin
            if (push)
                wrPtr <= wrPtr + 1'b1;
            if (pop)
                rdPtr <= rdPtr + 1'b1;

            unique case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase

            if (pop) begin
                outValid <= 1'b1;
                outD     <= capD;
                outNan   <= dNan;
                outInf   <= dInf;
            end else if (outValid && io.out_ready) begin
                outValid <= 1'b0;
            end
        end
    end

    assign io.in_ready  = inReady;
    assign io.count     = cnt;
    assign io.out_valid = outValid;
    assign io.out_d     = outD;
    assign io.out_nan   = outNan;
    assign io.out_inf   = outInf;
endmodule

// File: tb/tb_fma_issue_queue.sv
// Directed bench for fma_issue_queue with a table-driven stand-in for the FMA core.
module tb_fma_issue_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   failed = 0;

    fma_issue_queue_if #(.WIDTH(32), .CNT_W(3)) io ();

    fma_issue_queue #(.DEPTH(4), .WIDTH(32), .CNT_W(3)) dut (
        .clk(clk),
        .rst(rst),
        .io(io.slave)
    );

    always #5 clk = ~clk;

    // Known IEEE results for directed triples; anything else maps to an arbitrary mix.
    function automatic logic [31:0] core(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c);
        if (a == 32'h3F800000 && b == 32'h40000000 && c == 32'h40400000) return 32'h40A00000;
        if (a == 32'h7F800000 && b == 32'h00000000 && c == 32'h0) return 32'h7FC00000;
        if (a == 32'h7F800000 && b == 32'h3F800000 && c == 32'h0) return 32'h7F800000;
        if (a == 32'h00800000 && b == 32'h3F000000 && c == 32'h0) return 32'h00400000;
        if (a == 32'h0 && b == 32'h0 && c == 32'h0) return 32'h0;
        return a ^ {b[15:0], b[31:16]} ^ (c + 32'h11);
    endfunction

    always_comb io.fma_d = core(io.fma_a, io.fma_b, io.fma_c);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c);
        io.in_valid = v;
        io.in_a = a;
        io.in_b = b;
        io.in_c = c;
    endtask

    logic [31:0] va [10];
    logic [31:0] vb [10];
    logic [31:0] vc [10];

    initial begin
        for (int i = 0; i < 10; i++) begin
            va[i] = 32'h3F800000 + (i << 4);
            vb[i] = 32'h40000000 + (i << 8) + 32'h5;
            vc[i] = 32'h12340000 + i;
        end
        drive(1'b0, '0, '0, '0);
        io.out_ready = 1'b1;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_count", 32'(io.count), 32'd0);
        check("rst_in_ready", 32'(io.in_ready), 32'd1);
        check("rst_out_valid", 32'(io.out_valid), 32'd0);
        check("rst_out_d", io.out_d, 32'h0);
        check("rst_flags", {30'd0, io.out_nan, io.out_inf}, 32'd0);
        check("rst_fma_a", io.fma_a, 32'h0);

        // Single operation: 1*2+3
        drive(1'b1, 32'h3F800000, 32'h40000000, 32'h40400000);
        step();
        drive(1'b0, '0, '0, '0);
        check("one_count", 32'(io.count), 32'd1);
        check("one_valid_early", 32'(io.out_valid), 32'd0);
        check("one_head_a", io.fma_a, 32'h3F800000);
        step();
        check("one_valid", 32'(io.out_valid), 32'd1);
        check("one_d", io.out_d, 32'h40A00000);
        check("one_flags", {30'd0, io.out_nan, io.out_inf}, 32'd0);
        check("one_count_drained", 32'(io.count), 32'd0);
        step();
        check("one_valid_clear", 32'(io.out_valid), 32'd0);
        check("one_d_hold", io.out_d, 32'h40A00000);

        // Backpressure: first entry lands in output stage, next four fill the FIFO
        io.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, va[i], vb[i], vc[i]);
            step();
        end
        check("bp_count_full", 32'(io.count), 32'd4);
        check("bp_in_ready", 32'(io.in_ready), 32'd0);
        check("bp_out_d0", io.out_d, core(va[0], vb[0], vc[0]));
        drive(1'b1, va[5], vb[5], vc[5]);
        step();
        check("bp_refused_count", 32'(io.count), 32'd4);
        check("bp_hold_d", io.out_d, core(va[0], vb[0], vc[0]));
        drive(1'b0, '0, '0, '0);
        io.out_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            step();
            check($sformatf("bp_drain_valid%0d", i), 32'(io.out_valid), 32'd1);
            check($sformatf("bp_drain_d%0d", i), io.out_d, core(va[i], vb[i], vc[i]));
            check($sformatf("bp_drain_count%0d", i), 32'(io.count), 32'(4 - i));
        end
        step();
        check("bp_done_valid", 32'(io.out_valid), 32'd0);

        // Streaming through pointer wrap
        for (int k = 0; k < 11; k++) begin
            if (k < 10) drive(1'b1, va[k], vb[k], vc[k]);
            else drive(1'b0, '0, '0, '0);
            step();
            check($sformatf("st_count%0d", k), 32'(io.count <= 3'd1), 32'd1);
            if (k >= 1) begin
                check($sformatf("st_valid%0d", k), 32'(io.out_valid), 32'd1);
                check($sformatf("st_d%0d", k), io.out_d, core(va[k-1], vb[k-1], vc[k-1]));
            end
        end
        step();
        check("st_count_end", 32'(io.count), 32'd0);
        check("st_valid_end", 32'(io.out_valid), 32'd0);

        // NaN then Inf
        drive(1'b1, 32'h7F800000, 32'h00000000, 32'h0);
        step();
        drive(1'b0, '0, '0, '0);
        step();
        check("nan_d", io.out_d, 32'h7FC00000);
        check("nan_flags", {30'd0, io.out_nan, io.out_inf}, 32'd2);
        drive(1'b1, 32'h7F800000, 32'h3F800000, 32'h0);
        step();
        drive(1'b0, '0, '0, '0);
        step();
        check("inf_d", io.out_d, 32'h7F800000);
        check("inf_flags", {30'd0, io.out_nan, io.out_inf}, 32'd1);
        step();

        // Reset mid-operation with three queued and output stage full
        io.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, va[i], vb[i], vc[i]);
            step();
        end
        drive(1'b0, '0, '0, '0);
        check("mr_pre_count", 32'(io.count), 32'd3);
        check("mr_pre_valid", 32'(io.out_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        io.out_ready = 1'b1;
        check("mr_count", 32'(io.count), 32'd0);
        check("mr_valid", 32'(io.out_valid), 32'd0);
        check("mr_in_ready", 32'(io.in_ready), 32'd1);
        check("mr_fma", io.fma_a | io.fma_b | io.fma_c, 32'h0);
        check("mr_out_d", io.out_d, 32'h0);

        // Subnormal result
        drive(1'b1, 32'h00800000, 32'h3F000000, 32'h0);
        step();
        drive(1'b0, '0, '0, '0);
        step();
`ifdef FMA_FLUSH_DENORM_EN
        check("denorm_d", io.out_d, 32'h00000000);
`else
        check("denorm_d", io.out_d, 32'h00400000);
`endif
        check("denorm_flags", {30'd0, io.out_nan, io.out_inf}, 32'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", total, failed);
        $finish;
    end
endmodule
